// File: rtl/mem_access.sv
// mem_access: load/store stage between EX/MEM and MEM/WB with req/gnt/rvalid bus,
// lane alignment, misaligned/bus-error/timeout fault detection and upstream stall.
`default_nettype none

module mem_access #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk,
    input  logic        cpurst_n,
    input  logic        ex2mem_wr_reg_ffout,
    input  logic [4:0]  ex2mem_wr_regindex_ffout,
    input  logic [31:0] ex2mem_wr_wdata_ffout,
    input  logic [31:0] ex2mem_memaddr_ffout,
    input  logic [31:0] ex2mem_wr_memwdata_ffout,
    input  logic [2:0]  ex2mem_mem_op_ffout,
    input  logic        ex2mem_mem_en_ffout,
    input  logic        ex2mem_load_ffout,
    input  logic        ex2mem_store_ffout,
    input  logic        ex2mem_exp_ffout,
    input  logic [31:0] ex2mem_pc_ffout,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_gnt,
    input  logic        dbus_rvalid,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_err,
    output logic        memacc_stall,
    output logic        mem2wb_wr_reg,
    output logic [4:0]  mem2wb_wr_regindex,
    output logic [31:0] mem2wb_wr_wdata,
    output logic        mem2wb_exp,
    output logic [4:0]  mem2wb_causecode,
    output logic [31:0] mem2wb_mtval,
    output logic [31:0] mem2wb_pc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic        access;
    logic        misaligned;
    logic        start;
    logic        timeout;
    logic        done;
    logic        acc_fault;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [31:0] rshift;
    logic [31:0] load_data;

    logic        wb_wr_reg;
    logic [31:0] wb_wdata;
    logic        wb_exp;
    logic [4:0]  wb_cause;
    logic [31:0] wb_mtval;

    always_comb begin
        access     = ex2mem_mem_en_ffout & (ex2mem_load_ffout | ex2mem_store_ffout)
                     & ~ex2mem_exp_ffout;
        misaligned = ((ex2mem_mem_op_ffout[1:0] == 2'b01) & ex2mem_memaddr_ffout[0])
                   | ((ex2mem_mem_op_ffout[1:0] == 2'b10) & (ex2mem_memaddr_ffout[1:0] != 2'b00));
        start      = access & ~misaligned;
        timeout    = (state != IDLE) & (cnt == CNT_MAX);
        done       = (state == RESP) & dbus_rvalid;
        acc_fault  = (done & dbus_err) | (timeout & ~done);
        // Gated by reset so every output reads 0 while reset is held
        memacc_stall = cpurst_n & (((state == IDLE) & start)
                                 | ((state == REQ) & ~timeout)
                                 | ((state == RESP) & ~dbus_rvalid & ~timeout));
    end

    always_comb begin
        be_c    = 4'b1111;
        wdata_c = ex2mem_wr_memwdata_ffout;
        case (ex2mem_mem_op_ffout[1:0])
            2'b00: begin
                be_c    = 4'b0001 << ex2mem_memaddr_ffout[1:0];
                wdata_c = {4{ex2mem_wr_memwdata_ffout[7:0]}};
            end
            2'b01: begin
                be_c    = 4'b0011 << ex2mem_memaddr_ffout[1:0];
                wdata_c = {2{ex2mem_wr_memwdata_ffout[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        rshift    = dbus_rdata >> {ex2mem_memaddr_ffout[1:0], 3'b000};
        load_data = dbus_rdata;
        case (ex2mem_mem_op_ffout[1:0])
            2'b00:   load_data = ex2mem_mem_op_ffout[2] ? {24'd0, rshift[7:0]}
                                                        : {{24{rshift[7]}}, rshift[7:0]};
            2'b01:   load_data = ex2mem_mem_op_ffout[2] ? {16'd0, rshift[15:0]}
                                                        : {{16{rshift[15]}}, rshift[15:0]};
            default: load_data = dbus_rdata;
        endcase
    end

    // Next MEM/WB contents; only captured on cycles without stall
    always_comb begin
        wb_wr_reg = ex2mem_wr_reg_ffout;
        wb_wdata  = ex2mem_wr_wdata_ffout;
        wb_exp    = 1'b0;
        wb_cause  = 5'd0;
        wb_mtval  = 32'd0;
        if (state != IDLE) begin
            if (acc_fault) begin
                wb_wr_reg = 1'b0;
                wb_exp    = 1'b1;
                wb_cause  = ex2mem_load_ffout ? 5'd5 : 5'd7;
                wb_mtval  = ex2mem_memaddr_ffout;
            end else if (ex2mem_load_ffout) begin
                wb_wdata  = load_data;
            end else begin
                wb_wr_reg = 1'b0;
            end
        end else if (ex2mem_exp_ffout) begin
            wb_wr_reg = 1'b0;
            wb_exp    = 1'b1;
        end else if (access & misaligned) begin
            wb_wr_reg = 1'b0;
            wb_exp    = 1'b1;
            wb_cause  = ex2mem_load_ffout ? 5'd4 : 5'd6;
            wb_mtval  = ex2mem_memaddr_ffout;
        end
    end

    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_addr  <= 32'd0;
            dbus_be    <= 4'd0;
            dbus_wdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= REQ;
                        cnt        <= '0;
                        dbus_req   <= 1'b1;
                        dbus_we    <= ex2mem_store_ffout;
                        dbus_addr  <= {ex2mem_memaddr_ffout[31:2], 2'b00};
                        dbus_be    <= be_c;
                        dbus_wdata <= wdata_c;
                    end
                end
                REQ: begin
                    cnt <= cnt + 1'b1;
                    if (timeout) begin
                        state    <= IDLE;
                        dbus_req <= 1'b0;
                    end else if (dbus_gnt) begin
                        state    <= RESP;
                        dbus_req <= 1'b0;
                    end else if (cnt == CNT_PRE) begin
                        // Drop the request ahead of the timeout cycle
                        dbus_req <= 1'b0;
                    end
                end
                RESP: begin
                    cnt <= cnt + 1'b1;
                    if (dbus_rvalid || timeout) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    dbus_req <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            mem2wb_wr_reg      <= 1'b0;
            mem2wb_wr_regindex <= 5'd0;
            mem2wb_wr_wdata    <= 32'd0;
            mem2wb_exp         <= 1'b0;
            mem2wb_causecode   <= 5'd0;
            mem2wb_mtval       <= 32'd0;
            mem2wb_pc          <= 32'd0;
        end else if (!memacc_stall) begin
            mem2wb_wr_reg      <= wb_wr_reg;
            mem2wb_wr_regindex <= ex2mem_wr_regindex_ffout;
            mem2wb_wr_wdata    <= wb_wdata;
            mem2wb_exp         <= wb_exp;
            mem2wb_causecode   <= wb_cause;
            mem2wb_mtval       <= wb_mtval;
            mem2wb_pc          <= ex2mem_pc_ffout;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access.
`default_nettype none

module tb_mem_access;

    logic        clk;
    logic        cpurst_n;
    logic        wr_reg;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [2:0]  op;
    logic        mem_en;
    logic        load;
    logic        store;
    logic        exp_in;
    logic [31:0] pc;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_gnt;
    logic        dbus_rvalid;
    logic [31:0] dbus_rdata;
    logic        dbus_err;
    logic        memacc_stall;
    logic        wb_wr_reg;
    logic [4:0]  wb_rd;
    logic [31:0] wb_wdata;
    logic        wb_exp;
    logic [4:0]  wb_cause;
    logic [31:0] wb_mtval;
    logic [31:0] wb_pc;

    int checks   = 0;
    int failures = 0;
    int stalls;
    int bad;

    mem_access #(.TIMEOUT(64), .CNT_W(7)) dut (
        .clk                      (clk),
        .cpurst_n                 (cpurst_n),
        .ex2mem_wr_reg_ffout      (wr_reg),
        .ex2mem_wr_regindex_ffout (rd),
        .ex2mem_wr_wdata_ffout    (alu),
        .ex2mem_memaddr_ffout     (addr),
        .ex2mem_wr_memwdata_ffout (sdata),
        .ex2mem_mem_op_ffout      (op),
        .ex2mem_mem_en_ffout      (mem_en),
        .ex2mem_load_ffout        (load),
        .ex2mem_store_ffout       (store),
        .ex2mem_exp_ffout         (exp_in),
        .ex2mem_pc_ffout          (pc),
        .dbus_req                 (dbus_req),
        .dbus_we                  (dbus_we),
        .dbus_addr                (dbus_addr),
        .dbus_be                  (dbus_be),
        .dbus_wdata               (dbus_wdata),
        .dbus_gnt                 (dbus_gnt),
        .dbus_rvalid              (dbus_rvalid),
        .dbus_rdata               (dbus_rdata),
        .dbus_err                 (dbus_err),
        .memacc_stall             (memacc_stall),
        .mem2wb_wr_reg            (wb_wr_reg),
        .mem2wb_wr_regindex       (wb_rd),
        .mem2wb_wr_wdata          (wb_wdata),
        .mem2wb_exp               (wb_exp),
        .mem2wb_causecode         (wb_cause),
        .mem2wb_mtval             (wb_mtval),
        .mem2wb_pc                (wb_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    task automatic set_nop(input logic [31:0] p);
        wr_reg = 1'b0; rd = 5'd0; alu = 32'd0; addr = 32'd0; sdata = 32'd0;
        op = 3'b000; mem_en = 1'b0; load = 1'b0; store = 1'b0; exp_in = 1'b0; pc = p;
    endtask

    task automatic set_mem(input logic ld, input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] sd, input logic [31:0] p);
        wr_reg = ld; rd = 5'd7; alu = 32'd0; addr = a; sdata = sd; op = o;
        mem_en = 1'b1; load = ld; store = ~ld; exp_in = 1'b0; pc = p;
    endtask

    // Called at the negedge where the instruction was just presented; returns at the
    // negedge after the rvalid cycle with the instruction replaced by a nop.
    task automatic run_access(input int gw, input int rw, input logic [31:0] rdat,
                              input logic err, input logic [31:0] ea, input logic [3:0] ebe,
                              input logic [31:0] ewd);
        stalls = 0;
        bad    = 0;
        #1 if (memacc_stall) stalls++;
        @(negedge clk);
        for (int i = 0; i <= gw; i++) begin
            dbus_gnt = (i == gw);
            #1;
            if (memacc_stall) stalls++;
            if (!dbus_req || dbus_addr != ea || dbus_be != ebe || dbus_wdata != ewd) bad++;
            @(negedge clk);
        end
        dbus_gnt = 1'b0;
        for (int i = 0; i <= rw; i++) begin
            dbus_rvalid = (i == rw);
            dbus_rdata  = (i == rw) ? rdat : 32'h5A5A5A5A;
            dbus_err    = (i == rw) ? err : 1'b1;
            #1 if (memacc_stall) stalls++;
            @(negedge clk);
        end
        dbus_rvalid = 1'b0;
        dbus_err    = 1'b0;
        set_nop(32'h0);
        check("req_stable", bad, 0);
    endtask

    initial begin
        cpurst_n = 1'b0;
        dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = 32'd0; dbus_err = 1'b0;
        set_nop(32'h0);
        #12;
        check("rst_req", dbus_req, 0);
        check("rst_stall", memacc_stall, 0);
        check("rst_wb", {wb_wr_reg, wb_exp, wb_rd, wb_cause}, 0);
        check("rst_wb_data", wb_wdata | wb_pc | wb_mtval | dbus_addr, 0);
        @(negedge clk);
        cpurst_n = 1'b1;

        // Non-memory pass-through
        @(negedge clk);
        set_nop(32'h100);
        wr_reg = 1'b1; rd = 5'd5; alu = 32'h1234;
        #1 check("nop_stall", memacc_stall, 0);
        @(negedge clk);
        #1;
        check("nop_wdata", wb_wdata, 32'h1234);
        check("nop_rd", wb_rd, 5);
        check("nop_wr", wb_wr_reg, 1);
        check("nop_pc", wb_pc, 32'h100);

        // LB sign extension, no wait states: byte 3 of 0x80FFFFFF is 0x80
        set_mem(1'b1, 3'b000, 32'h1003, 32'h0, 32'h104);
        run_access(0, 0, 32'h80FFFFFF, 1'b0, 32'h1000, 4'b1000, 32'h0);
        #1;
        check("lb_stalls", stalls, 2);
        check("lb_data", wb_wdata, 32'hFFFFFF80);
        check("lb_wr", wb_wr_reg, 1);
        check("lb_exp", wb_exp, 0);

        // LBU same stimulus
        @(negedge clk);
        set_mem(1'b1, 3'b100, 32'h1003, 32'h0, 32'h108);
        run_access(0, 0, 32'h80FFFFFF, 1'b0, 32'h1000, 4'b1000, 32'h0);
        #1;
        check("lbu_data", wb_wdata, 32'h00000080);

        // SH with wait states: 1 idle + 4 req + 2 resp-wait stall cycles
        @(negedge clk);
        set_mem(1'b0, 3'b001, 32'h2002, 32'h0000ABCD, 32'h10C);
        run_access(3, 2, 32'h0, 1'b0, 32'h2000, 4'b1100, 32'hABCDABCD);
        #1;
        check("sh_stalls", stalls, 7);
        check("sh_we", dbus_we, 1);
        check("sh_wr", wb_wr_reg, 0);
        check("sh_exp", wb_exp, 0);

        // Misaligned LW
        @(negedge clk);
        set_mem(1'b1, 3'b010, 32'h3001, 32'h0, 32'h110);
        #1;
        check("mis_stall", memacc_stall, 0);
        @(negedge clk);
        set_nop(32'h0);
        #1;
        check("mis_req", dbus_req, 0);
        check("mis_exp", wb_exp, 1);
        check("mis_cause", wb_cause, 4);
        check("mis_mtval", wb_mtval, 32'h3001);
        check("mis_wr", wb_wr_reg, 0);

        // Bus error on SW
        @(negedge clk);
        set_mem(1'b0, 3'b010, 32'h4000, 32'h11223344, 32'h114);
        run_access(0, 0, 32'h0, 1'b1, 32'h4000, 4'b1111, 32'h11223344);
        #1;
        check("err_exp", wb_exp, 1);
        check("err_cause", wb_cause, 7);
        check("err_mtval", wb_mtval, 32'h4000);

        // Timeout on LW: 1 idle + 64 req stall cycles, stall drops on the 65th busy cycle
        @(negedge clk);
        set_mem(1'b1, 3'b010, 32'h5000, 32'h0, 32'h118);
        stalls = 0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (!memacc_stall) break;
            stalls++;
            @(negedge clk);
        end
        check("to_stalls", stalls, 65);
        check("to_req", dbus_req, 0);
        @(negedge clk);
        set_nop(32'h0);
        #1;
        check("to_exp", wb_exp, 1);
        check("to_cause", wb_cause, 5);
        check("to_mtval", wb_mtval, 32'h5000);
        check("to_wr", wb_wr_reg, 0);

        // Asynchronous reset while waiting in RESP
        @(negedge clk);
        set_mem(1'b1, 3'b010, 32'h6000, 32'h0, 32'h11C);
        @(negedge clk);
        dbus_gnt = 1'b1;
        @(negedge clk);
        dbus_gnt = 1'b0;
        #2 cpurst_n = 1'b0;
        #1;
        check("arst_stall", memacc_stall, 0);
        check("arst_req", dbus_req, 0);
        check("arst_wb", wb_pc | wb_mtval | {31'd0, wb_exp} | {31'd0, wb_wr_reg}, 0);
        @(negedge clk);
        set_nop(32'h0);
        cpurst_n = 1'b1;
        @(negedge clk);
        set_mem(1'b1, 3'b010, 32'h6004, 32'h0, 32'h120);
        run_access(0, 0, 32'hDEADBEEF, 1'b0, 32'h6004, 4'b1111, 32'h0);
        #1;
        check("post_stalls", stalls, 2);
        check("post_data", wb_wdata, 32'hDEADBEEF);
        check("post_wr", wb_wr_reg, 1);
        check("post_rd", wb_rd, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
